// File: rtl/gps_track_channel.sv
// GPS early/prompt/late correlator channel with lock detection.
//
// The 1-bit IF sample is wiped off against three code replicas and the carrier NCO
// sign bits. Six saturating I/Q integrators are dumped on the dump strobe. A 3-stage
// pipeline then forms I^2+Q^2 per tap, the early-minus-late discriminator and the
// prompt I sign. A lock FSM tracks consecutive prompt-power threshold hits and misses.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                channel enable; low clears integrators, flushes pipeline, IDLE
//   sample_en, data_in    sample strobe and IF sign bit
//   dump                  integrate-and-dump strobe
//   prn_e/prn_p/prn_l     early/prompt/late code chips
//   sin, cos              carrier NCO sign bits
//   lock_thresh           unsigned prompt-power lock threshold
//   p_early/p_prompt/p_late  unsigned tap powers
//   disc                  signed p_early - p_late
//   ip_sign               prompt I < 0 (navigation bit estimate)
//   out_valid             one-cycle pulse when the outputs update
//   lock, state           lock flag and FSM state (IDLE=0, ACQ=1, LOCKED=2)
module gps_track_channel #(
  parameter int unsigned ACC_W    = 14,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 8,
  localparam int unsigned PW      = 2 * ACC_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sample_en,
  input  logic                 dump,
  input  logic                 data_in,
  input  logic                 prn_e,
  input  logic                 prn_p,
  input  logic                 prn_l,
  input  logic                 sin,
  input  logic                 cos,
  input  logic [PW-1:0]        lock_thresh,
  output logic [PW-1:0]        p_early,
  output logic [PW-1:0]        p_prompt,
  output logic [PW-1:0]        p_late,
  output logic signed [PW:0]   disc,
  output logic                 ip_sign,
  output logic                 out_valid,
  output logic                 lock,
  output logic [1:0]           state
);

  localparam int unsigned SqW = 2 * ACC_W;
  localparam logic signed [ACC_W-1:0] AccOne = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  // Symmetric saturation: the most negative code is never produced.
  localparam logic signed [ACC_W-1:0] AccMin = -AccMax;
  localparam logic [3:0] LockCnt = 4'(LOCK_CNT);
  localparam logic [3:0] LossCnt = 4'(LOSS_CNT);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAcq    = 2'd1,
    StLocked = 2'd2
  } state_e;

  // Accumulator index: 0/1 early I/Q, 2/3 prompt I/Q, 4/5 late I/Q.
  logic [2:0]              prn;
  logic [5:0]              neg_bits;
  logic signed [ACC_W-1:0] acc_q   [6];
  logic signed [ACC_W-1:0] acc_sum [6];

  logic signed [ACC_W-1:0] s1_q    [6];
  logic                    v1_q;
  logic signed [SqW-1:0]   s1_ext  [6];
  logic [SqW-1:0]          sq_d    [6];
  logic [SqW-1:0]          sq_q    [6];
  logic                    ip_neg_q;
  logic                    v2_q;

  logic [PW-1:0]           pe_d, pp_d, pl_d;
  logic [PW:0]             disc_d;

  state_e                  state_q, state_d;
  logic [3:0]              hit_q, hit_d;
  logic [3:0]              miss_q, miss_d;

  assign prn = {prn_l, prn_p, prn_e};

  // A set bit means the product is -1, a clear bit +1.
  always_comb begin
    neg_bits = '0;
    for (int t = 0; t < 3; t++) begin
      neg_bits[2*t]   = data_in ^ prn[t] ^ sin;
      neg_bits[2*t+1] = data_in ^ prn[t] ^ cos;
    end
  end

  // Running sum including this cycle's sample; also the value captured on a dump.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      acc_sum[k] = acc_q[k];
      if (sample_en) begin
        if (neg_bits[k]) begin
          if (acc_q[k] != AccMin) acc_sum[k] = acc_q[k] - AccOne;
        end else begin
          if (acc_q[k] != AccMax) acc_sum[k] = acc_q[k] + AccOne;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 6; k++) acc_q[k] <= '0;
    end else if (!enable || dump) begin
      for (int k = 0; k < 6; k++) acc_q[k] <= '0;
    end else if (sample_en) begin
      for (int k = 0; k < 6; k++) acc_q[k] <= acc_sum[k];
    end
  end

  // Stage 1: capture dumped sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 6; k++) s1_q[k] <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= enable & dump;
      if (enable && dump) begin
        for (int k = 0; k < 6; k++) s1_q[k] <= acc_sum[k];
      end
    end
  end

  // Stage 2: full-precision squares of sign-extended sums.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      s1_ext[k] = {{ACC_W{s1_q[k][ACC_W-1]}}, s1_q[k]};
      sq_d[k]   = s1_ext[k] * s1_ext[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 6; k++) sq_q[k] <= '0;
      ip_neg_q <= 1'b0;
      v2_q     <= 1'b0;
    end else begin
      v2_q <= enable & v1_q;
      if (v1_q) begin
        for (int k = 0; k < 6; k++) sq_q[k] <= sq_d[k];
        ip_neg_q <= s1_q[2][ACC_W-1];
      end
    end
  end

  // Stage 3: powers and discriminator.
  always_comb begin
    pe_d   = {1'b0, sq_q[0]} + {1'b0, sq_q[1]};
    pp_d   = {1'b0, sq_q[2]} + {1'b0, sq_q[3]};
    pl_d   = {1'b0, sq_q[4]} + {1'b0, sq_q[5]};
    disc_d = {1'b0, pe_d} - {1'b0, pl_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_early   <= '0;
      p_prompt  <= '0;
      p_late    <= '0;
      disc      <= '0;
      ip_sign   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= enable & v2_q;
      if (enable && v2_q) begin
        p_early  <= pe_d;
        p_prompt <= pp_d;
        p_late   <= pl_d;
        disc     <= disc_d;
        ip_sign  <= ip_neg_q;
      end
    end
  end

  // Lock FSM consumes the stage-3 prompt power as it is registered, so lock/state
  // change on the same edge that raises out_valid.
  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    if (!enable) begin
      state_d = StIdle;
      hit_d   = '0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StAcq;
          hit_d   = '0;
          miss_d  = '0;
        end
        StAcq: begin
          if (v2_q) begin
            if (pp_d >= lock_thresh) begin
              if (hit_q + 4'd1 == LockCnt) begin
                state_d = StLocked;
                hit_d   = '0;
              end else begin
                hit_d = hit_q + 4'd1;
              end
            end else begin
              hit_d = '0;
            end
          end
        end
        StLocked: begin
          if (v2_q) begin
            if (pp_d < lock_thresh) begin
              if (miss_q + 4'd1 == LossCnt) begin
                state_d = StAcq;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + 4'd1;
              end
            end else begin
              miss_d = '0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign state = state_q;
  assign lock  = (state_q == StLocked);

endmodule

// File: tb/tb_gps_track_channel.sv
// Scoreboard bench for gps_track_channel (ACC_W=8, LOCK_CNT=2, LOSS_CNT=3).
// The stimulus process models the integrators and queues the expected outputs
// of every accepted dump; each out_valid pops one entry and also advances a
// behavioural lock FSM model.
module tb_gps_track_channel;

  localparam int ACC_W    = 8;
  localparam int LOCK_CNT = 2;
  localparam int LOSS_CNT = 3;
  localparam int PW       = 2 * ACC_W + 1;
  localparam int AMAX     = 2 ** (ACC_W - 1) - 1;

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic                sample_en;
  logic                dump;
  logic                data_in;
  logic                prn_e, prn_p, prn_l;
  logic                sin, cos;
  logic [PW-1:0]       lock_thresh;
  logic [PW-1:0]       p_early, p_prompt, p_late;
  logic signed [PW:0]  disc;
  logic                ip_sign;
  logic                out_valid;
  logic                lock;
  logic [1:0]          state;

  gps_track_channel #(
    .ACC_W    (ACC_W),
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sample_en   (sample_en),
    .dump        (dump),
    .data_in     (data_in),
    .prn_e       (prn_e),
    .prn_p       (prn_p),
    .prn_l       (prn_l),
    .sin         (sin),
    .cos         (cos),
    .lock_thresh (lock_thresh),
    .p_early     (p_early),
    .p_prompt    (p_prompt),
    .p_late      (p_late),
    .disc        (disc),
    .ip_sign     (ip_sign),
    .out_valid   (out_valid),
    .lock        (lock),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pe;
    int pp;
    int pl;
    int dsc;
    bit ips;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pops = 0;
  int   last_pop_cyc = 0;
  int   prev_pop_cyc = 0;
  int   acc[6];
  int   m_state = 0;
  int   m_hit = 0;
  int   m_miss = 0;
  int   thr = 1000;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int a, input bit neg);
    if (neg) return (a > -AMAX) ? a - 1 : a;
    return (a < AMAX) ? a + 1 : a;
  endfunction

  task automatic clear_model();
    sb_q.delete();
    acc = '{default: 0};
    m_state = 0;
    m_hit = 0;
    m_miss = 0;
  endtask

  // Called #1 after each rising edge.
  task automatic monitor();
    exp_t e;
    cyc++;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        if (m_state == 1) begin
          if (e.pp >= thr) begin
            m_hit++;
            if (m_hit == LOCK_CNT) begin m_state = 2; m_hit = 0; end
          end else m_hit = 0;
        end else if (m_state == 2) begin
          if (e.pp < thr) begin
            m_miss++;
            if (m_miss == LOSS_CNT) begin m_state = 1; m_miss = 0; end
          end else m_miss = 0;
        end
        check("p_early", p_early, e.pe);
        check("p_prompt", p_prompt, e.pp);
        check("p_late", p_late, e.pl);
        check("disc", disc, e.dsc);
        check("ip_sign", ip_sign, e.ips);
        check("lock", lock, (m_state == 2) ? 1 : 0);
        check("state", state, m_state);
        prev_pop_cyc = last_pop_cyc;
        last_pop_cyc = cyc;
        pops++;
      end
    end
  endtask

  // Apply the current inputs for one clock, updating the model first.
  task automatic step();
    int     nxt[6];
    bit [2:0] prnv;
    bit     x;
    exp_t   e;
    if (!enable || !rst_n) begin
      // Dumps still in the first two pipeline stages are flushed by this edge.
      clear_model();
    end else begin
      if (m_state == 0) m_state = 1;
      prnv = {prn_l, prn_p, prn_e};
      for (int t = 0; t < 3; t++) begin
        x = data_in ^ prnv[t];
        nxt[2*t]   = sample_en ? sat(acc[2*t], x ^ sin) : acc[2*t];
        nxt[2*t+1] = sample_en ? sat(acc[2*t+1], x ^ cos) : acc[2*t+1];
      end
      if (dump) begin
        e.pe  = nxt[0] * nxt[0] + nxt[1] * nxt[1];
        e.pp  = nxt[2] * nxt[2] + nxt[3] * nxt[3];
        e.pl  = nxt[4] * nxt[4] + nxt[5] * nxt[5];
        e.dsc = e.pe - e.pl;
        e.ips = (nxt[2] < 0);
        sb_q.push_back(e);
        acc = '{default: 0};
      end else begin
        acc = nxt;
      end
    end
    @(posedge clk);
    #1;
    monitor();
  endtask

  // kind 0: all chips match data, carrier 0; 1: late inverted; 2: late chip 0;
  // 3: everything random; 4: matched with sin=1 (prompt I negative).
  task automatic samples(input int n, input int kind, input bit dump_last);
    for (int i = 0; i < n; i++) begin
      bit d;
      d = 1'($urandom_range(0, 1));
      sample_en = 1'b1;
      dump = dump_last && (i == n - 1);
      data_in = d;
      sin = 1'b0;
      cos = 1'b0;
      case (kind)
        0: begin prn_e = d; prn_p = d; prn_l = d; end
        1: begin prn_e = d; prn_p = d; prn_l = ~d; end
        2: begin
          if (i < 2) data_in = 1'(i);
          prn_e = data_in; prn_p = data_in; prn_l = 1'b0;
        end
        4: begin prn_e = d; prn_p = d; prn_l = d; sin = 1'b1; end
        default: begin
          prn_e = 1'($urandom_range(0, 1));
          prn_p = 1'($urandom_range(0, 1));
          prn_l = 1'($urandom_range(0, 1));
          sin   = 1'($urandom_range(0, 1));
          cos   = 1'($urandom_range(0, 1));
        end
      endcase
      step();
    end
    sample_en = 1'b0;
    dump = 1'b0;
  endtask

  task automatic idle(input int n);
    sample_en = 1'b0;
    dump = 1'b0;
    repeat (n) step();
  endtask

  task automatic dump_only();
    sample_en = 1'b0;
    dump = 1'b1;
    step();
    dump = 1'b0;
  endtask

  task automatic drain(input string tag);
    idle(5);
    check(tag, sb_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p_early"}, p_early, 0);
    check({tag, "_p_prompt"}, p_prompt, 0);
    check({tag, "_p_late"}, p_late, 0);
    check({tag, "_disc"}, disc, 0);
    check({tag, "_ip_sign"}, ip_sign, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_lock"}, lock, 0);
    check({tag, "_state"}, state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int dump_cyc;
    rst_n = 1'b0; enable = 1'b0; sample_en = 1'b0; dump = 1'b0;
    data_in = 1'b0; prn_e = 1'b0; prn_p = 1'b0; prn_l = 1'b0;
    sin = 1'b0; cos = 1'b0;
    lock_thresh = PW'(thr);
    clear_model();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    enable = 1'b1;
    idle(2);

    // 100 matched samples: I=Q=100 on every tap.
    samples(100, 0, 0);
    dump_only();
    dump_cyc = cyc;
    drain("drain_100");
    // dump occupies the cycle closed by tick dump_cyc; out_valid is high three
    // cycles after that dump cycle, i.e. two ticks later.
    check("lat_100", last_pop_cyc - dump_cyc, 2);
    check("c100_pp", p_prompt, 20000);
    check("c100_disc", disc, 0);
    check("c100_ips", ip_sign, 0);

    // 200 samples saturate at 127.
    samples(200, 0, 0);
    dump_only();
    drain("drain_sat");
    check("sat_pp", p_prompt, 32258);
    check("sat_pe", p_early, 32258);

    // Early matched, late inverted: I=Q=+50 vs -50.
    samples(50, 1, 0);
    dump_only();
    drain("drain_el");
    check("el_pe", p_early, 5000);
    check("el_pl", p_late, 5000);
    check("el_disc", disc, 0);

    samples(50, 2, 0);
    dump_only();
    drain("drain_lzero");
    check("disc_pos", (disc > 0) ? 1 : 0, 1);

    // Random pattern, dump coincident with a sample.
    samples(37, 3, 1);
    drain("drain_rand");

    // Negative prompt I.
    samples(30, 4, 1);
    drain("drain_neg");
    check("neg_ips", ip_sign, 1);
    check("neg_pp", p_prompt, 1800);

    // Drop enable while locked.
    check("locked_before_off", lock, 1);
    enable = 1'b0;
    step();
    check("off_state", state, 0);
    check("off_lock", lock, 0);

    // Dump while disabled is ignored.
    p0 = pops;
    dump = 1'b1;
    step();
    dump = 1'b0;
    idle(5);
    check("off_dump_pops", pops, p0);
    check("off_dump_state", state, 0);
    enable = 1'b1;
    idle(1);

    // Lock acquisition and loss with lock_thresh=1000.
    samples(100, 0, 0);
    dump_only();
    drain("drain_acq1");
    check("acq1_lock", lock, 0);
    check("acq1_state", state, 1);
    samples(100, 0, 0);
    dump_only();
    drain("drain_acq2");
    check("acq2_lock", lock, 1);
    dump_only();
    drain("drain_miss1");
    dump_only();
    drain("drain_miss2");
    check("miss2_state", state, 2);
    dump_only();
    drain("drain_miss3");
    check("miss3_state", state, 1);

    // Back-to-back dumps.
    samples(10, 3, 1);
    samples(1, 3, 1);
    drain("drain_b2b");
    check("b2b_spacing", last_pop_cyc - prev_pop_cyc, 1);

    // Enable falls one and two cycles after a dump.
    samples(20, 0, 0);
    p0 = pops;
    dump_only();
    enable = 1'b0;
    step();
    enable = 1'b1;
    drain("drain_flush1");
    check("flush1_pops", pops, p0);
    samples(20, 0, 0);
    dump_only();
    idle(1);
    enable = 1'b0;
    step();
    enable = 1'b1;
    drain("drain_flush2");
    check("flush2_pops", pops, p0);

    // Reset mid-integration and mid-pipeline.
    samples(30, 3, 0);
    dump_only();
    samples(1, 3, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pops;
    idle(6);
    check("postrst_pops", pops, p0);

    // First integration after reset starts from zero.
    samples(100, 0, 1);
    drain("drain_postrst");
    check("postrst_pp", p_prompt, 20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
